serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 19 +
 rtl/tx_bit_counter.sv | 38 +++
 rtl/serial_tx.sv | 99 +++++++++
 tb/tb_serial_tx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_pkg
// Brief    : Shared types and defaults for the serial transmitter/receiver pair.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } tx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/tx_bit_counter.sv
//------------------------------------------------------------------------------
// Module   : tx_bit_counter
// Brief    : Loadable down-counter tracking the bits left in the current frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tx_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic R,
  input  logic load,
  input  logic dec,
  output logic is_zero
);

  localparam logic [CNT_W-1:0] c_LOAD_VAL = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (R) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_LOAD_VAL;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - c_ONE;
    end
  end

  assign is_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
//------------------------------------------------------------------------------
// Module   : serial_tx
// Brief    : Parallel-in, MSB-first serial-out transmitter with ready/load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_tx
  import serial_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_is_zero;
  logic             w_accept;
  logic             w_dec;

  assign ready    = (r_state == S_IDLE) || ((r_state == S_SHIFT) && w_is_zero);
  assign w_accept = load && ready;
  assign w_dec    = (r_state == S_SHIFT) && !w_is_zero;

  tx_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .R       (R),
    .load    (w_accept),
    .dec     (w_dec),
    .is_zero (w_is_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_shreg_nxt = din;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!w_is_zero) begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
          // Last bit on the line: frame completes whether or not a new word chains on.
          w_done_nxt = 1'b1;
          if (load) begin
            w_shreg_nxt = din;
          end else begin
            w_shreg_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shreg_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign sout       = (r_state == S_SHIFT) && r_shreg[WIDTH-1];
  assign sout_valid = (r_state == S_SHIFT);
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_tx
// Brief    : Directed, table-driven bench for serial_tx (WIDTH = 8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_tx;

  logic       clk;
  logic       R;
  logic       load;
  logic [7:0] din;
  logic       ready;
  logic       sout;
  logic       sout_valid;
  logic       done;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       r;
    logic       load;
    logic [7:0] din;
    logic       rdy;
    logic       sout;
    logic       vld;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  serial_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .R          (R),
    .load       (load),
    .din        (din),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: inputs applied before an edge, outputs expected just after it.
  task automatic add(input logic r, input logic ld, input logic [7:0] d,
                     input logic rdy, input logic so, input logic v, input logic dn);
    vec_t e;
    e.r = r; e.load = ld; e.din = d;
    e.rdy = rdy; e.sout = so; e.vld = v; e.done = dn;
    vecs.push_back(e);
  endtask

  task automatic add_frame(input logic [7:0] w, input logic hold, input logic chained);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, (i == 0) ? 1'b1 : hold, w, (i == 7), w[7-i], 1'b1, (i == 0) && chained);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rdy,sout,vld,done}=%b, want %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {ready, sout, sout_valid, done};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    R = 1'b1; load = 1'b0; din = 8'h00;

    // Reset then idle
    add(1, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0);
    // Single frame A5
    add_frame(8'hA5, 1'b0, 1'b0);
    add(0, 0, 8'h00, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0);
    // Back-to-back A5 then 3C with load held
    add_frame(8'hA5, 1'b1, 1'b0);
    add_frame(8'h3C, 1'b0, 1'b1);
    add(0, 0, 8'h00, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0);

    foreach (vecs[k]) begin
      R = vecs[k].r; load = vecs[k].load; din = vecs[k].din;
      tick();
      chk($sformatf("vec%0d", k), outs(),
          {vecs[k].rdy, vecs[k].sout, vecs[k].vld, vecs[k].done});
    end

    // Load during a frame is ignored
    R = 0; load = 1; din = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ign_bit%0d", i), outs(), {(i == 7), 1'b1, 1'b1, 1'b0});
      load = (i == 2); din = (i == 2) ? 8'h00 : 8'hFF;
      tick();
    end
    load = 0;
    chk("ign_done", outs(), 4'b1001);
    tick();
    chk("ign_single_done", outs(), 4'b1000);

    // Reset mid-frame aborts, then a fresh frame goes out intact
    load = 1; din = 8'hC3;
    tick();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_bit%0d", i), outs(), {1'b0, (i < 2), 1'b1, 1'b0});
      R = (i == 3);
      tick();
    end
    R = 0;
    chk("abort_after_r", outs(), 4'b1000);
    tick();
    chk("abort_no_done", outs(), 4'b1000);
    load = 1; din = 8'h81;
    tick();
    load = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fresh_bit%0d", i), outs(), {(i == 7), (i == 0 || i == 7), 1'b1, 1'b0});
      tick();
    end
    chk("fresh_done", outs(), 4'b1001);

    // Reset has priority over load at the same edge
    R = 1; load = 1; din = 8'hFF;
    tick();
    chk("r_vs_load", outs(), 4'b1000);
    R = 0; load = 0;
    tick();
    chk("r_vs_load_idle", outs(), 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
